// File: rtl/gear_pkg.sv
// Shared gear encodings and display codes for the shift controller and display.
package gear_pkg;

  typedef enum logic [1:0] {
    GEAR_P = 2'd0,
    GEAR_R = 2'd1,
    GEAR_N = 2'd2,
    GEAR_D = 2'd3
  } gear_e;

  localparam logic [3:0] GEAR_CHAR_P = 4'd3;
  localparam logic [3:0] GEAR_CHAR_R = 4'd6;
  localparam logic [3:0] GEAR_CHAR_N = 4'd9;
  localparam logic [3:0] GEAR_CHAR_D = 4'd12;

  // 1-digit indicator code for a gear; every encoding maps to a legal code.
  function automatic logic [3:0] gear_to_char(input gear_e g);
    case (g)
      GEAR_P:  gear_to_char = GEAR_CHAR_P;
      GEAR_R:  gear_to_char = GEAR_CHAR_R;
      GEAR_N:  gear_to_char = GEAR_CHAR_N;
      default: gear_to_char = GEAR_CHAR_D;
    endcase
  endfunction

endpackage

// File: rtl/gear_shift_ctrl_if.sv
// Button/pedal inputs and gear status outputs of the shift controller.
interface gear_shift_ctrl_if;
  logic       tick_db;
  logic       btn_up;
  logic       btn_down;
  logic       brake;
  logic [7:0] speed;
  logic [3:0] gear_char;
  logic [1:0] gear_state;
  logic       park_lock;
  logic       reverse_lamp;
  logic       shift_reject;

  modport master (
    output tick_db, btn_up, btn_down, brake, speed,
    input  gear_char, gear_state, park_lock, reverse_lamp, shift_reject
  );

  modport slave (
    input  tick_db, btn_up, btn_down, brake, speed,
    output gear_char, gear_state, park_lock, reverse_lamp, shift_reject
  );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, tick-sampled debounce counter and a
// one-clk request pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_req
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_TICKS - 1);

  logic       r_sync1, r_sync2;
  logic       r_deb, r_deb_d;
  logic [7:0] r_cnt;
  logic       r_req;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level starts high so a button held through reset must be
  // released and pressed again before it can request a shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb <= 1'b1;
      r_cnt <= 8'd0;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= 8'd0;
    end else if (i_tick) begin
      if (r_cnt == CNT_LAST) begin
        r_deb <= r_sync2;
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Request pulse one cycle after the debounced level goes 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_d <= 1'b1;
      r_req   <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
      r_req   <= r_deb & ~r_deb_d;
    end
  end

  assign o_req = r_req;

endmodule

// File: rtl/gear_shift_ctrl.sv
// Turns debounced up/down requests into P/R/N/D with brake/speed interlocks.
module gear_shift_ctrl
  import gear_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic           clk,
  input  logic           rst,
  gear_shift_ctrl_if.slave bus
);

  // bit 0 = up, bit 1 = down
  logic [1:0] w_btn_raw;
  logic [1:0] w_req;

  assign w_btn_raw = {bus.btn_down, bus.btn_up};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_tick (bus.tick_db),
      .i_btn  (w_btn_raw[g]),
      .o_req  (w_req[g])
    );
  end

  gear_e r_gear, w_gear_nxt;
  logic  r_reject, w_reject_nxt;
  logic  w_stopped;

  assign w_stopped = (bus.speed == 8'd0);

  // Gear register and registered reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gear   <= GEAR_P;
      r_reject <= 1'b0;
    end else begin
      r_gear   <= w_gear_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  // Shift decision using this cycle's brake and speed; conflicting requests
  // are both refused.
  always_comb begin
    w_gear_nxt   = r_gear;
    w_reject_nxt = 1'b0;
    if (w_req[0] && w_req[1]) begin
      w_reject_nxt = 1'b1;
    end else if (w_req[0]) begin
      case (r_gear)
        GEAR_P:  if (bus.brake && w_stopped) w_gear_nxt = GEAR_R;
                 else w_reject_nxt = 1'b1;
        GEAR_R:  w_gear_nxt = GEAR_N;
        GEAR_N:  if (bus.brake || !w_stopped) w_gear_nxt = GEAR_D;
                 else w_reject_nxt = 1'b1;
        default: w_reject_nxt = 1'b1;
      endcase
    end else if (w_req[1]) begin
      case (r_gear)
        GEAR_D:  w_gear_nxt = GEAR_N;
        GEAR_N:  if (bus.brake && w_stopped) w_gear_nxt = GEAR_R;
                 else w_reject_nxt = 1'b1;
        GEAR_R:  if (w_stopped) w_gear_nxt = GEAR_P;
                 else w_reject_nxt = 1'b1;
        default: w_reject_nxt = 1'b1;
      endcase
    end
  end

  assign bus.gear_state   = r_gear;
  assign bus.gear_char    = gear_to_char(r_gear);
  assign bus.park_lock    = (r_gear == GEAR_P);
  assign bus.reverse_lamp = (r_gear == GEAR_R);
  assign bus.shift_reject = r_reject;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed bench: button presses with hand-computed gear/reject expectations.
module tb_gear_shift_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rej_cnt = 0;
  int   tick_ph = 0;

  gear_shift_ctrl_if bus();

  gear_shift_ctrl #(.DEBOUNCE_TICKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One-clk tick every 10 clk, changed away from the active edge.
  always @(negedge clk) begin
    tick_ph = (tick_ph == 9) ? 0 : tick_ph + 1;
    bus.tick_db = (tick_ph == 0);
  end

  // Count cycles the reject output is high.
  always @(negedge clk) begin
    if (rst) rej_cnt = 0;
    else if (bus.shift_reject) rej_cnt = rej_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic hold_up);
    @(negedge clk);
    bus.btn_up = hold_up;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
  endtask

  // Press for hold clk, release, then let the debounced level settle low.
  task automatic press(input logic up, input logic dn, input int hold);
    @(negedge clk);
    bus.btn_up = up;
    bus.btn_down = dn;
    wait_clk(hold);
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    wait_clk(80);
  endtask

  task automatic chk_gear(input string tag, input logic [1:0] st, input logic [3:0] ch);
    chk({tag, "_state"}, 32'(bus.gear_state), 32'(st));
    chk({tag, "_char"},  32'(bus.gear_char),  32'(ch));
  endtask

  int r0;

  initial begin
    rst = 1'b1;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.brake = 1'b0;
    bus.speed = 8'd0;
    bus.tick_db = 1'b0;

    // Reset and idle
    do_reset(1'b0);
    chk("rst_park", 32'(bus.park_lock), 32'd1);
    chk("rst_rev",  32'(bus.reverse_lamp), 32'd0);
    chk("rst_rej",  32'(bus.shift_reject), 32'd0);
    wait_clk(200);
    chk_gear("idle", 2'd0, 4'd3);
    chk("idle_park", 32'(bus.park_lock), 32'd1);
    chk("idle_rej", 32'(rej_cnt), 32'd0);

    // P->R->N->D with brake, stopped
    bus.brake = 1'b1;
    press(1'b1, 1'b0, 60);
    chk_gear("up_pr", 2'd1, 4'd6);
    chk("up_pr_rev",  32'(bus.reverse_lamp), 32'd1);
    chk("up_pr_park", 32'(bus.park_lock), 32'd0);
    press(1'b1, 1'b0, 60);
    chk_gear("up_rn", 2'd2, 4'd9);
    chk("up_rn_rev", 32'(bus.reverse_lamp), 32'd0);
    press(1'b1, 1'b0, 60);
    chk_gear("up_nd", 2'd3, 4'd12);
    chk("up_ok_rej", 32'(rej_cnt), 32'd0);

    // Up at D refused
    r0 = rej_cnt;
    press(1'b1, 1'b0, 60);
    chk_gear("up_d", 2'd3, 4'd12);
    chk("up_d_rej", 32'(rej_cnt - r0), 32'd1);

    // P->R without brake refused
    do_reset(1'b0);
    wait_clk(80);
    bus.brake = 1'b0;
    bus.speed = 8'd0;
    press(1'b1, 1'b0, 60);
    chk_gear("pr_nobrk", 2'd0, 4'd3);
    chk("pr_nobrk_rej", 32'(rej_cnt), 32'd1);

    // Down at P refused
    press(1'b0, 1'b1, 60);
    chk_gear("dn_p", 2'd0, 4'd3);
    chk("dn_p_rej", 32'(rej_cnt), 32'd2);

    // Climb to N; N->D with no brake and stopped refused, then with brake
    bus.brake = 1'b1;
    press(1'b1, 1'b0, 60);
    press(1'b1, 1'b0, 60);
    bus.brake = 1'b0;
    r0 = rej_cnt;
    press(1'b1, 1'b0, 60);
    chk_gear("nd_stop", 2'd2, 4'd9);
    chk("nd_stop_rej", 32'(rej_cnt - r0), 32'd1);
    bus.brake = 1'b1;
    press(1'b1, 1'b0, 60);
    chk_gear("nd_brk", 2'd3, 4'd12);

    // Moving: D->N ok, N->R refused, then stopped with brake -> R
    bus.brake = 1'b0;
    bus.speed = 8'd40;
    r0 = rej_cnt;
    press(1'b0, 1'b1, 60);
    chk_gear("dn_dn", 2'd2, 4'd9);
    press(1'b0, 1'b1, 60);
    chk_gear("dn_nr_mov", 2'd2, 4'd9);
    chk("dn_nr_rej", 32'(rej_cnt - r0), 32'd1);
    bus.speed = 8'd0;
    bus.brake = 1'b1;
    press(1'b0, 1'b1, 60);
    chk_gear("dn_nr", 2'd1, 4'd6);

    // R->P refused while moving
    bus.speed = 8'd5;
    r0 = rej_cnt;
    press(1'b0, 1'b1, 60);
    chk_gear("dn_rp_mov", 2'd1, 4'd6);
    chk("dn_rp_rej", 32'(rej_cnt - r0), 32'd1);
    bus.speed = 8'd0;

    // Short glitch: nothing; long hold: exactly one step R->N
    r0 = rej_cnt;
    press(1'b1, 1'b0, 25);
    chk_gear("glitch", 2'd1, 4'd6);
    chk("glitch_rej", 32'(rej_cnt - r0), 32'd0);
    press(1'b1, 1'b0, 300);
    chk_gear("hold", 2'd2, 4'd9);
    chk("hold_rej", 32'(rej_cnt - r0), 32'd0);

    // Button held across reset: no shift until released and pressed again
    do_reset(1'b1);
    wait_clk(100);
    chk_gear("held_rst", 2'd0, 4'd3);
    chk("held_rst_rej", 32'(rej_cnt), 32'd0);
    bus.btn_up = 1'b0;
    wait_clk(80);
    press(1'b1, 1'b0, 60);
    chk_gear("held_rel", 2'd1, 4'd6);

    // Both buttons together: discarded, one reject
    r0 = rej_cnt;
    press(1'b1, 1'b1, 60);
    chk_gear("both", 2'd1, 4'd6);
    chk("both_rej", 32'(rej_cnt - r0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
